// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer.
//   - state_t        : sequencer FSM states
//   - WS_*           : write-source encodings for instruction bits [29:28]
//   - *_BIT/_MSB/_LSB: instruction field bit positions
//   - instr_fields_t : decoded instruction fields
//   - sext_imm()     : sign-extends the 23-bit immediate to 32 bits
package seq_pkg;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    WAIT_IN = 3'd3,
    WB      = 3'd4
  } state_t;

  localparam logic [1:0] WS_IMM  = 2'b00;
  localparam logic [1:0] WS_SW   = 2'b01;
  localparam logic [1:0] WS_ALU  = 2'b10;
  localparam logic [1:0] WS_NONE = 2'b11;

  localparam int unsigned J_BIT     = 31;
  localparam int unsigned B_BIT     = 30;
  localparam int unsigned WS_MSB    = 29;
  localparam int unsigned WS_LSB    = 28;
  localparam int unsigned ALUOP_MSB = 27;
  localparam int unsigned ALUOP_LSB = 23;
  localparam int unsigned RA1_MSB   = 22;
  localparam int unsigned RA1_LSB   = 18;
  localparam int unsigned RA2_MSB   = 17;
  localparam int unsigned RA2_LSB   = 13;
  localparam int unsigned OFF_MSB   = 12;
  localparam int unsigned OFF_LSB   = 5;
  localparam int unsigned WA_MSB    = 4;
  localparam int unsigned WA_LSB    = 0;
  localparam int unsigned IMM_MSB   = 27;
  localparam int unsigned IMM_LSB   = 5;

  typedef struct packed {
    logic        j;
    logic        b;
    logic [1:0]  ws;
    logic [4:0]  aluop;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [7:0]  off;
    logic [4:0]  wa;
    logic [31:0] imm;
  } instr_fields_t;

  // The immediate shares bits with ALUOP/RA1/RA2/OFF; it is only meaningful for WS_IMM.
  function automatic logic [31:0] sext_imm(input logic [22:0] imm);
    return {{9{imm[22]}}, imm};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// instr_decode: purely combinational split of the instruction register.
//   ir     in  32  instruction register contents
//   fields out     decoded fields plus sign-extended immediate
//   wr_en  out 1   instruction writes the register file (WS != none and WA != r0)
module instr_decode
  import seq_pkg::*;
(
  input  logic [31:0]   ir,
  output instr_fields_t fields,
  output logic          wr_en
);

  assign fields.j     = ir[J_BIT];
  assign fields.b     = ir[B_BIT];
  assign fields.ws    = ir[WS_MSB:WS_LSB];
  assign fields.aluop = ir[ALUOP_MSB:ALUOP_LSB];
  assign fields.ra1   = ir[RA1_MSB:RA1_LSB];
  assign fields.ra2   = ir[RA2_MSB:RA2_LSB];
  assign fields.off   = ir[OFF_MSB:OFF_LSB];
  assign fields.wa    = ir[WA_MSB:WA_LSB];
  assign fields.imm   = sext_imm(ir[IMM_MSB:IMM_LSB]);

  // r0 is never written, so WA=0 suppresses the write just like WS=none.
  assign wr_en = (fields.ws != WS_NONE) && (fields.wa != 5'd0);

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/(WAIT_IN)/WB controller.
// Owns PC and IR, drives the register file ports and ALU opcode, and
// accepts external switch data through a valid/ready handshake.
//   CLK, rst            clock, synchronous active-high reset
//   imem_addr/rdata     instruction ROM (data valid one cycle after address)
//   rf_a1/a2            register file read addresses (IR fields)
//   rf_a3/wd3/we3       register file write port, we3 pulses in WB only
//   alu_op              ALU opcode (IR field)
//   alu_result/flag     combinational ALU outputs, captured in EXEC
//   sw_in/valid/ready   switch input handshake, ready only in WAIT_IN
//   retire              one-cycle pulse per completed instruction (WB)
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic            CLK,
  input  logic            rst,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [4:0]      rf_a1,
  output logic [4:0]      rf_a2,
  output logic [4:0]      rf_a3,
  output logic [31:0]     rf_wd3,
  output logic            rf_we3,
  output logic [4:0]      alu_op,
  input  logic [31:0]     alu_result,
  input  logic            alu_flag,
  input  logic [31:0]     sw_in,
  input  logic            sw_valid,
  output logic            sw_ready,
  output logic            retire
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [31:0]     res_q, res_d;
  logic            flg_q, flg_d;
  logic            we_q, we_d;
  logic            retire_q, retire_d;
  logic            sw_ready_q, sw_ready_d;

  instr_fields_t   dec;
  logic            dec_wr_en;
  logic [PC_W-1:0] off_pc;
  logic            take_off;

  instr_decode u_decode (
    .ir     (ir_q),
    .fields (dec),
    .wr_en  (dec_wr_en)
  );

  // Signed word offset, reduced modulo 2^PC_W by the add below.
  assign off_pc   = PC_W'($signed(dec.off));
  // J wins over B; B uses the flag captured in this instruction's EXEC.
  assign take_off = dec.j | (dec.b & flg_q);

  assign imem_addr = pc_q;
  assign rf_a1     = dec.ra1;
  assign rf_a2     = dec.ra2;
  assign alu_op    = dec.aluop;
  assign rf_a3     = dec.wa;
  assign rf_wd3    = (dec.ws == WS_IMM) ? dec.imm : res_q;
  assign rf_we3    = we_q;
  assign retire    = retire_q;
  assign sw_ready  = sw_ready_q;

  // Next-state, datapath capture and next-cycle output strobes.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    res_d   = res_q;
    flg_d   = flg_q;
    case (state_q)
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        ir_d    = imem_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        res_d = alu_result;
        flg_d = alu_flag;
        if (dec.ws == WS_SW) begin
          state_d = WAIT_IN;
        end else begin
          state_d = WB;
        end
      end
      WAIT_IN: begin
        if (sw_valid && sw_ready_q) begin
          res_d   = sw_in;
          state_d = WB;
        end else begin
          state_d = WAIT_IN;
        end
      end
      WB: begin
        if (take_off) begin
          pc_d = pc_q + off_pc;
        end else begin
          pc_d = pc_q + PC_W'(1'b1);
        end
        state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    // Strobes are registered so they line up exactly with the state they belong to.
    we_d       = (state_d == WB) && dec_wr_en;
    retire_d   = (state_d == WB);
    sw_ready_d = (state_d == WAIT_IN);
  end

  // State, PC, IR, captured result/flag and output strobe registers.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= '0;
      ir_q       <= 32'd0;
      res_q      <= 32'd0;
      flg_q      <= 1'b0;
      we_q       <= 1'b0;
      retire_q   <= 1'b0;
      sw_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      res_q      <= res_d;
      flg_q      <= flg_d;
      we_q       <= we_d;
      retire_q   <= retire_d;
      sw_ready_q <= sw_ready_d;
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a ROM model plus a queue of expected
// per-instruction outcomes (write, next fetch address, latency, handshake).
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int PC_W = 8;

  logic            CLK = 1'b0;
  logic            rst;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [4:0]      rf_a1, rf_a2, rf_a3, alu_op;
  logic [31:0]     rf_wd3;
  logic            rf_we3;
  logic [31:0]     alu_result;
  logic            alu_flag;
  logic [31:0]     sw_in;
  logic            sw_valid;
  logic            sw_ready;
  logic            retire;

  logic [31:0] rom [0:255];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] word;
    logic        we;
    logic [31:0] wd3;
    logic [7:0]  next_pc;
    int          lat;
    int          sw_delay;
    int          sw_cycles;
    logic [31:0] sw_data;
  } exp_t;

  exp_t sb[$];

  instr_sequencer #(.PC_W(PC_W)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .rf_a1      (rf_a1),
    .rf_a2      (rf_a2),
    .rf_a3      (rf_a3),
    .rf_wd3     (rf_wd3),
    .rf_we3     (rf_we3),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_flag   (alu_flag),
    .sw_in      (sw_in),
    .sw_valid   (sw_valid),
    .sw_ready   (sw_ready),
    .retire     (retire)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read instruction ROM.
  always @(posedge CLK) imem_rdata <= rom[imem_addr];

  function automatic logic [31:0] enc(logic j, logic b, logic [1:0] ws, logic [4:0] op,
                                      logic [4:0] r1, logic [4:0] r2, logic [7:0] off,
                                      logic [4:0] wa);
    return {j, b, ws, op, r1, r2, off, wa};
  endfunction

  function automatic logic [31:0] enc_imm(logic [22:0] imm, logic [4:0] wa);
    return {1'b0, 1'b0, WS_IMM, imm, wa};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [31:0] word, logic we, logic [31:0] wd3, logic [7:0] next_pc,
                      int lat, int sw_delay, int sw_cycles, logic [31:0] sw_data);
    exp_t e;
    e.word = word; e.we = we; e.wd3 = wd3; e.next_pc = next_pc;
    e.lat = lat; e.sw_delay = sw_delay; e.sw_cycles = sw_cycles; e.sw_data = sw_data;
    sb.push_back(e);
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_we3"},       32'(rf_we3),    32'd0);
    chk({tag, "_sw_ready"},  32'(sw_ready),  32'd0);
    chk({tag, "_retire"},    32'(retire),    32'd0);
    chk({tag, "_a1"},        32'(rf_a1),     32'd0);
    chk({tag, "_a2"},        32'(rf_a2),     32'd0);
    chk({tag, "_a3"},        32'(rf_a3),     32'd0);
    chk({tag, "_alu_op"},    32'(alu_op),    32'd0);
    chk({tag, "_wd3"},       rf_wd3,         32'd0);
  endtask

  // Called at the negedge of a FETCH cycle; runs one instruction to its retire
  // and then checks the following fetch address.
  task automatic run_one(string tag);
    exp_t e;
    int   n;
    int   rdy;
    logic done;
    e = sb.pop_front();
    n = 0; rdy = 0; done = 1'b0;
    while (!done && n < 64) begin
      @(negedge CLK);
      n++;
      if (n == 2) begin
        chk({tag, "_alu_op"}, 32'(alu_op), 32'(e.word[27:23]));
        chk({tag, "_a1"},     32'(rf_a1),  32'(e.word[22:18]));
        chk({tag, "_a2"},     32'(rf_a2),  32'(e.word[17:13]));
      end
      if (sw_ready) begin
        rdy++;
        if (rdy > e.sw_delay) begin
          sw_valid = 1'b1;
          sw_in    = e.sw_data;
        end else begin
          sw_valid = 1'b0;
        end
      end
      if (retire) begin
        done = 1'b1;
      end else begin
        chk({tag, "_we_outside_wb"}, 32'(rf_we3), 32'd0);
      end
    end
    chk({tag, "_retired"}, 32'(done), 32'd1);
    sw_valid = 1'b0;
    chk({tag, "_latency"},   n + 1, e.lat);
    chk({tag, "_sw_ready_cycles"}, rdy, e.sw_cycles);
    chk({tag, "_we3"}, 32'(rf_we3), 32'(e.we));
    if (e.we) begin
      chk({tag, "_a3"},  32'(rf_a3), 32'(e.word[4:0]));
      chk({tag, "_wd3"}, rf_wd3, e.wd3);
    end
    @(negedge CLK);
    chk({tag, "_retire_single"}, 32'(retire), 32'd0);
    chk({tag, "_we3_after"},     32'(rf_we3), 32'd0);
    chk({tag, "_fetch_addr"},    32'(imem_addr), 32'(e.next_pc));
  endtask

  initial begin
    logic [31:0] w;
    int   k;
    rst        = 1'b1;
    sw_valid   = 1'b0;
    sw_in      = 32'd0;
    alu_result = 32'd0;
    alu_flag   = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = enc(1'b0, 1'b0, WS_NONE, 5'd0, 5'd0, 5'd0, 8'd0, 5'd0);

    rom[0]  = enc_imm(23'h7FFFFB, 5'd3);
    rom[1]  = enc(1'b0, 1'b0, WS_ALU,  5'd0, 5'd1, 5'd2, 8'd0,   5'd4);
    rom[2]  = enc(1'b1, 1'b0, WS_NONE, 5'd0, 5'd0, 5'd0, 8'd3,   5'd0);
    rom[5]  = enc(1'b0, 1'b1, WS_NONE, 5'd0, 5'd0, 5'd0, 8'hFD,  5'd0);
    rom[6]  = enc(1'b1, 1'b1, WS_NONE, 5'd0, 5'd0, 5'd0, 8'd3,   5'd0);
    rom[9]  = enc(1'b0, 1'b0, WS_SW,   5'd0, 5'd0, 5'd0, 8'd0,   5'd7);
    rom[10] = enc_imm(23'h000055, 5'd0);
    rom[11] = enc(1'b0, 1'b0, WS_NONE, 5'd9, 5'd0, 5'd0, 8'd0,   5'd5);
    rom[12] = enc(1'b1, 1'b0, WS_NONE, 5'd0, 5'd0, 5'd0, 8'd0,   5'd0);

    // Reset state.
    repeat (2) @(negedge CLK);
    chk_reset_outputs("reset");
    rst = 1'b0;
    chk("first_fetch_addr", 32'(imem_addr), 32'd0);

    // Immediate write of -5 to r3; ALU result must not leak into the write.
    alu_result = 32'hDEAD_BEEF;
    push(rom[0], 1'b1, 32'hFFFF_FFFB, 8'd1, 4, 0, 0, 32'd0);
    run_one("imm_neg5");

    // ALU write 0x12 to r4.
    alu_result = 32'h0000_0012;
    push(rom[1], 1'b1, 32'h0000_0012, 8'd2, 4, 0, 0, 32'd0);
    run_one("alu_wr");

    alu_result = 32'h1111_1111;
    alu_flag   = 1'b0;
    push(rom[2], 1'b0, 32'd0, 8'd5, 4, 0, 0, 32'd0);
    run_one("jump_fwd");

    alu_flag = 1'b1;
    push(rom[5], 1'b0, 32'd0, 8'd2, 4, 0, 0, 32'd0);
    run_one("branch_taken");

    alu_flag = 1'b0;
    push(rom[2], 1'b0, 32'd0, 8'd5, 4, 0, 0, 32'd0);
    run_one("jump_fwd2");

    push(rom[5], 1'b0, 32'd0, 8'd6, 4, 0, 0, 32'd0);
    run_one("branch_not_taken");

    // J has priority over B with flag=0; a stray sw_valid here must be ignored.
    sw_valid = 1'b1;
    sw_in    = 32'h0000_0BAD;
    push(rom[6], 1'b0, 32'd0, 8'd9, 4, 0, 0, 32'd0);
    run_one("jump_prio");

    // Switch input: ready for 11 cycles (10 waiting + accept), 4+11 total.
    push(rom[9], 1'b1, 32'h0000_CAFE, 8'd10, 15, 10, 11, 32'h0000_CAFE);
    run_one("switch");

    push(rom[10], 1'b0, 32'd0, 8'd11, 4, 0, 0, 32'd0);
    run_one("wa0_no_write");

    push(rom[11], 1'b0, 32'd0, 8'd12, 4, 0, 0, 32'd0);
    run_one("ws11_no_write");

    push(rom[12], 1'b0, 32'd0, 8'd12, 4, 0, 0, 32'd0);
    run_one("halt_loop1");
    push(rom[12], 1'b0, 32'd0, 8'd12, 4, 0, 0, 32'd0);
    run_one("halt_loop2");

    // Reset while waiting in WAIT_IN at PC=20.
    rom[0]  = enc(1'b1, 1'b0, WS_NONE, 5'd0, 5'd0, 5'd0, 8'd20, 5'd0);
    rom[20] = enc(1'b0, 1'b0, WS_SW,   5'd3, 5'd6, 5'd9, 8'd0,  5'd7);
    rst = 1'b1;
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    push(rom[0], 1'b0, 32'd0, 8'd20, 4, 0, 0, 32'd0);
    run_one("jump_to_20");
    k = 0;
    while (!sw_ready && k < 20) begin
      @(negedge CLK);
      k++;
    end
    chk("wait_in_reached", 32'(sw_ready), 32'd1);
    repeat (2) @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    chk_reset_outputs("rst_wait_in");
    rst = 1'b0;
    push(rom[0], 1'b0, 32'd0, 8'd20, 4, 0, 0, 32'd0);
    run_one("restart_after_wait_rst");

    // PC wrap 255 -> 0, then reset while PC=255.
    rom[0] = enc(1'b1, 1'b0, WS_NONE, 5'd0, 5'd0, 5'd0, 8'hFF, 5'd0);
    rst = 1'b1;
    repeat (2) @(negedge CLK);
    rst = 1'b0;
    push(rom[0], 1'b0, 32'd0, 8'd255, 4, 0, 0, 32'd0);
    run_one("jump_back_255");
    push(rom[255], 1'b0, 32'd0, 8'd0, 4, 0, 0, 32'd0);
    run_one("pc_wrap");
    push(rom[0], 1'b0, 32'd0, 8'd255, 4, 0, 0, 32'd0);
    run_one("jump_back_255b");
    @(negedge CLK);
    rst = 1'b1;
    @(negedge CLK);
    chk_reset_outputs("rst_pc255");
    rst = 1'b0;
    w = rom[0];
    push(w, 1'b0, 32'd0, 8'd255, 4, 0, 0, 32'd0);
    run_one("restart_after_pc255_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
